testmasterslave11_source: RTL

- Upstream producer stage for testmasterslave11.
- Accepts integer samples from a blocking handshake input and accumulates them.
- Emits the running sum on an integer output with a one-cycle sync strobe, which drives the downstream s_in/s_in_sync pair.
- Drives a shared status bit, shared_out, that feeds the downstream shared_in.

---
 rtl/testmasterslave11_source_pkg.sv | 23 ++
 rtl/testmasterslave11_source_if.sv | 38 +++
 rtl/testmasterslave11_source.sv | 77 +++++++
 3 files changed

// File: rtl/testmasterslave11_source_pkg.sv
// Shared types for the testmasterslave11 source stage: the common 32-bit signed
// sample type and the source FSM's section encoding and parameter defaults.

package top_level_types;

    typedef logic signed [31:0] int32_t;

endpackage

package testmasterslave11_source_types;

    typedef enum logic [1:0] {
        sec_init  = 2'd0,
        sec_wait  = 2'd1,
        sec_accum = 2'd2,
        sec_emit  = 2'd3
    } Sections_src;

    localparam int signed DEF_THRESHOLD = 100;
    localparam int signed DEF_INIT_VAL  = 0;
    localparam int        DEF_CNT_W     = 8;

endpackage

// File: rtl/testmasterslave11_source_if.sv
// Handshake bundle between the upstream producer, the source stage and the
// downstream consumer (s_in / s_in_sync / shared_in side).

interface testmasterslave11_source_if
    import top_level_types::*;
#(
    parameter int CNT_W = 8
);

    int32_t           b_in;
    logic             b_in_sync;
    logic             b_in_notify;
    int32_t           m_out;
    logic             m_out_sync;
    logic             shared_out;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        input  b_in,
        input  b_in_sync,
        output b_in_notify,
        output m_out,
        output m_out_sync,
        output shared_out,
        output txn_cnt
    );

    modport slave (
        output b_in,
        output b_in_sync,
        input  b_in_notify,
        input  m_out,
        input  m_out_sync,
        input  shared_out,
        input  txn_cnt
    );

endinterface

// File: rtl/testmasterslave11_source.sv
// Source stage: takes one sample per round from a blocking handshake, keeps a
// running signed sum and emits it with a one-cycle strobe plus a threshold flag.

module testmasterslave11_source
    import top_level_types::*;
    import testmasterslave11_source_types::*;
#(
    parameter int signed THRESHOLD = DEF_THRESHOLD,
    parameter int signed INIT_VAL  = DEF_INIT_VAL,
    parameter int        CNT_W     = DEF_CNT_W
) (
    input logic                        clk,
    input logic                        rst,
    testmasterslave11_source_if.master bus
);

    Sections_src      section_q;
    int32_t           acc_q;
    int32_t           data_q;
    int32_t           m_out_q;
    logic             m_out_sync_q;
    logic             shared_out_q;
    logic [CNT_W-1:0] txn_cnt_q;

    // Ready comes straight from the section register so the upstream never
    // sees a combinational loop back through b_in_sync.
    assign bus.b_in_notify = (section_q == sec_wait);
    assign bus.m_out       = m_out_q;
    assign bus.m_out_sync  = m_out_sync_q;
    assign bus.shared_out  = shared_out_q;
    assign bus.txn_cnt     = txn_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_q    <= sec_init;
            acc_q        <= INIT_VAL;
            data_q       <= '0;
            m_out_q      <= '0;
            m_out_sync_q <= 1'b0;
            shared_out_q <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            m_out_sync_q <= 1'b0;
            case (section_q)
                sec_init: begin
                    section_q <= sec_wait;
                end
                sec_wait: begin
                    if (bus.b_in_sync) begin
                        data_q    <= bus.b_in;
                        section_q <= sec_accum;
                    end
                end
                sec_accum: begin
                    // A zero sample is a clear command rather than a no-op add.
                    if (data_q == 0) begin
                        acc_q <= INIT_VAL;
                    end else begin
                        acc_q <= acc_q + data_q;
                    end
                    section_q <= sec_emit;
                end
                sec_emit: begin
                    m_out_q      <= acc_q;
                    m_out_sync_q <= 1'b1;
                    shared_out_q <= (acc_q > THRESHOLD);
                    txn_cnt_q    <= CNT_W'(txn_cnt_q + 1'b1);
                    section_q    <= sec_wait;
                end
                default: begin
                    section_q <= sec_init;
                end
            endcase
        end
    end

endmodule
